// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: ALU opcode encoding used by the execute stage
// and by any block that borrows the ALU.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Bundle between the sequential multiplier, the pipeline that requests a
// multiply, and the shared ALU the multiplier borrows.
//   slave  : the multiplier's view
//   master : the pipeline / ALU side
interface alu_mult_seq_if;
    import cpu_types_pkg::*;

    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    aluop_t      alu_op;
    logic [31:0] alu_port_a;
    logic [31:0] alu_port_b;
    logic [31:0] alu_out;

    modport slave (
        input  start, op_a, op_b, alu_out,
        output busy, done, result, alu_op, alu_port_a, alu_port_b
    );

    modport master (
        output start, op_a, op_b, alu_out,
        input  busy, done, result, alu_op, alu_port_a, alu_port_b
    );

endinterface

// File: rtl/alu_mult_seq.sv
// Shift-and-add multiplier controller. Produces the low 32 bits of a*b by
// issuing every accumulate (ALU_ADD) and multiplicand shift (ALU_SLL) to the
// shared combinational ALU and registering what comes back. A set multiplier
// bit costs a STEP (add) plus a SHIFT; a clear bit shifts directly in STEP.
module alu_mult_seq
    import cpu_types_pkg::*;
#(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic          CLK,
    input  logic          nRST,
    alu_mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] result_r;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic        done_r;

    logic [31:0] acc_nxt_s;
    logic [31:0] mcand_nxt_s;
    logic [31:0] mplier_nxt_s;
    logic [4:0]  cnt_nxt_s;
    aluop_t      alu_op_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [31:0] mplier_shr_s;
    logic        last_shift_s;

    // The shift about to happen is the last one if all 32 bits are done or,
    // with early termination, no set multiplier bits remain above it.
    always_comb begin
        mplier_shr_s = mplier_r >> 1;
        last_shift_s = (cnt_r == 5'd31) ||
                       ((EARLY_TERM == 1'b1) && (mplier_shr_s == 32'd0));
    end

    // Next-state and ALU request decode; the ALU is idle-parked at ADD 0+0.
    always_comb begin
        state_nxt_s  = state_r;
        acc_nxt_s    = acc_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        cnt_nxt_s    = cnt_r;
        alu_op_s     = ALU_ADD;
        alu_a_s      = 32'd0;
        alu_b_s      = 32'd0;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt_s    = 32'd0;
                    mcand_nxt_s  = bus.op_a;
                    mplier_nxt_s = bus.op_b;
                    cnt_nxt_s    = 5'd0;
                    if ((EARLY_TERM == 1'b1) && (bus.op_b == 32'd0)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = STEP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            STEP: begin
                if (mplier_r[0]) begin
                    alu_op_s    = ALU_ADD;
                    alu_a_s     = acc_r;
                    alu_b_s     = mcand_r;
                    acc_nxt_s   = bus.alu_out;
                    state_nxt_s = SHIFT;
                end else begin
                    // Clear multiplier bit: nothing to add, shift right away.
                    alu_op_s     = ALU_SLL;
                    alu_a_s      = mcand_r;
                    alu_b_s      = 32'd1;
                    mcand_nxt_s  = bus.alu_out;
                    mplier_nxt_s = mplier_shr_s;
                    cnt_nxt_s    = cnt_r + 5'd1;
                    state_nxt_s  = last_shift_s ? DONE : STEP;
                end
            end

            SHIFT: begin
                alu_op_s     = ALU_SLL;
                alu_a_s      = mcand_r;
                alu_b_s      = 32'd1;
                mcand_nxt_s  = bus.alu_out;
                mplier_nxt_s = mplier_shr_s;
                cnt_nxt_s    = cnt_r + 5'd1;
                state_nxt_s  = last_shift_s ? DONE : STEP;
            end

            DONE: begin
                state_nxt_s = IDLE;
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r  <= IDLE;
            acc_r    <= 32'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            cnt_r    <= 5'd0;
            result_r <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            cnt_r    <= cnt_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= (state_nxt_s == DONE);
            // Capture the final accumulator as DONE is entered; held after.
            if ((state_nxt_s == DONE) && (state_r != DONE)) begin
                result_r <= acc_nxt_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result     = result_r;
    assign bus.alu_op     = alu_op_s;
    assign bus.alu_port_a = alu_a_s;
    assign bus.alu_port_b = alu_b_s;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: one instance per EARLY_TERM setting (index = value),
// each with its own behavioural ALU. Expected products, latencies and ALU
// request sequences come from a bit-by-bit long-multiplication model.
module tb_alu_mult_seq;
    import cpu_types_pkg::*;

    typedef struct packed {
        aluop_t      op;
        logic [31:0] pa;
        logic [31:0] pb;
    } ent_t;

    logic        clk;
    logic        nrst;
    logic        start_v  [2];
    logic [31:0] opa_v    [2];
    logic [31:0] opb_v    [2];
    logic        busy_v   [2];
    logic        done_v   [2];
    logic [31:0] result_v [2];
    aluop_t      op_v     [2];
    logic [31:0] pa_v     [2];
    logic [31:0] pb_v     [2];

    int n_cmp;
    int n_fail;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_mult_seq_if bus ();

        assign bus.start  = start_v[g];
        assign bus.op_a   = opa_v[g];
        assign bus.op_b   = opb_v[g];
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign result_v[g] = bus.result;
        assign op_v[g]     = bus.alu_op;
        assign pa_v[g]     = bus.alu_port_a;
        assign pb_v[g]     = bus.alu_port_b;
        assign bus.alu_out = (bus.alu_op == ALU_ADD) ? (bus.alu_port_a + bus.alu_port_b) :
                             (bus.alu_op == ALU_SLL) ? (bus.alu_port_a << bus.alu_port_b[4:0]) :
                             32'd0;

        alu_mult_seq #(.EARLY_TERM(g == 1)) dut (
            .CLK  (clk),
            .nRST (nrst),
            .bus  (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply on instance et and check it end to end.
    task automatic run_mult(input int et, input logic [31:0] a, input logic [31:0] b,
                            input bit disturb);
        ent_t        exp_q[$];
        ent_t        obs_q[$];
        logic [31:0] accm;
        logic [31:0] mc;
        logic [31:0] prod;
        int          nbits;
        int          ndiff;
        int          cyc;

        // Reference: long multiplication over the bits the controller walks.
        prod  = a * b;
        nbits = 32;
        if (et == 1) begin
            nbits = 0;
            for (int i = 0; i < 32; i++) if (b[i]) nbits = i + 1;
        end
        accm = 32'd0;
        mc   = a;
        for (int i = 0; i < nbits; i++) begin
            if (b[i]) begin
                exp_q.push_back('{ALU_ADD, accm, mc});
                accm = accm + mc;
            end
            exp_q.push_back('{ALU_SLL, mc, 32'd1});
            mc = mc << 1;
        end

        @(negedge clk);
        start_v[et] = 1'b1;
        opa_v[et]   = a;
        opb_v[et]   = b;
        @(posedge clk);
        #1;
        start_v[et] = 1'b0;
        cyc = 1;
        while (cyc < 120) begin
            if (done_v[et]) break;
            if (busy_v[et]) obs_q.push_back('{op_v[et], pa_v[et], pb_v[et]});
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 2) begin
                start_v[et] = 1'b1;
                opa_v[et]   = 32'h0000_0063;
                opb_v[et]   = 32'h0000_0063;
            end
            if (disturb && cyc == 4) start_v[et] = 1'b0;
        end

        chk("done_seen", done_v[et], 1'b1);
        chk("latency", cyc, exp_q.size() + 1);
        chk("result", result_v[et], prod);
        chk("busy_in_done", busy_v[et], 1'b1);
        chk("done_alu_op", op_v[et], ALU_ADD);
        chk("done_alu_ports", {pa_v[et], pb_v[et]}, 64'd0);
        chk("alu_seq_len", obs_q.size(), exp_q.size());
        ndiff = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) ndiff++;
        chk("alu_seq_diff", ndiff, 0);

        @(posedge clk);
        #1;
        chk("post_done", done_v[et], 1'b0);
        chk("post_busy", busy_v[et], 1'b0);
        chk("result_held", result_v[et], prod);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp  = 0;
        n_fail = 0;
        nrst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            opa_v[i]   = 32'd0;
            opb_v[i]   = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy_v[i], 1'b0);
            chk("rst_done", done_v[i], 1'b0);
            chk("rst_result", result_v[i], 32'd0);
            chk("rst_alu_op", op_v[i], ALU_ADD);
            chk("rst_alu_ports", {pa_v[i], pb_v[i]}, 64'd0);
        end
        @(negedge clk);
        nrst = 1'b1;

        // Directed cases
        run_mult(1, 32'd3, 32'd5, 1'b0);
        run_mult(1, 32'h0000_1234, 32'd0, 1'b0);
        run_mult(0, 32'h0000_1234, 32'd0, 1'b0);
        run_mult(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mult(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mult(1, 32'h8000_0000, 32'd2, 1'b0);
        run_mult(1, 32'd7, 32'h8000_0000, 1'b0);
        run_mult(0, 32'd3, 32'd5, 1'b0);
        // Start pulses with new operands mid-run are ignored
        run_mult(1, 32'd6, 32'd7, 1'b1);
        run_mult(0, 32'd6, 32'd7, 1'b1);

        // start held high: a new multiply on every return to IDLE
        @(negedge clk);
        start_v[1] = 1'b1;
        opa_v[1]   = 32'd5;
        opb_v[1]   = 32'd0;
        @(posedge clk);
        #1;
        chk("hold_done1", done_v[1], 1'b1);
        @(posedge clk);
        #1;
        chk("hold_idle_done", done_v[1], 1'b0);
        chk("hold_idle_busy", busy_v[1], 1'b0);
        @(posedge clk);
        #1;
        chk("hold_done2", done_v[1], 1'b1);
        chk("hold_result", result_v[1], 32'd0);
        start_v[1] = 1'b0;
        @(posedge clk);
        #1;

        // Reset while in SHIFT abandons the multiply
        run_mult(1, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        start_v[1] = 1'b1;
        opa_v[1]   = 32'd3;
        opb_v[1]   = 32'd5;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        chk("pre_rst_add", op_v[1], ALU_ADD);
        @(posedge clk);
        #1;
        chk("pre_rst_sll", op_v[1], ALU_SLL);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy_v[1], 1'b0);
        chk("midrst_done", done_v[1], 1'b0);
        chk("midrst_result", result_v[1], 32'd0);
        chk("midrst_alu_op", op_v[1], ALU_ADD);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_done", done_v[1], 1'b0);
        run_mult(1, 32'd2, 32'd3, 1'b0);

        // Randomized operands with varied multiplier widths on both variants
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (k % 8 == 7) rb = 32'd0;
            run_mult(k % 2, ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle shift-and-add multiplier controller that borrows the shared 32-bit ALU to compute the low 32 bits of a*b.
- The block keeps only operand and accumulator registers. Every add and every multiplicand shift is issued to the ALU as ALU_ADD or ALU_SLL, and the block registers the ALU result.
- Sits beside the execute stage. The pipeline stalls on busy.

Parameters:
- EARLY_TERM, default 1: 1 ends the loop when the remaining multiplier is zero; 0 always walks all 32 bits.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- op_a  in  32  multiplicand, captured on accepted start
- op_b  in  32  multiplier, captured on accepted start
- busy  out  1  high in STEP, SHIFT and DONE
- done  out  1  one-cycle pulse in DONE
- result  out  32  a*b mod 2^32; valid from the done cycle; held until the next accepted start
- alu_op  out  aluop_t  opcode driven to the ALU (cpu_types_pkg)
- alu_port_a  out  32  ALU operand A
- alu_port_b  out  32  ALU operand B
- alu_out  in  32  ALU result, combinational, same cycle

Behaviour:
- Reset and interface:
  - One clock. Reset is synchronous and active-low: nRST low on a rising CLK edge forces the reset state.
  - Reset state: state=IDLE, acc=0, mcand=0, mplier=0, result=0, busy=0, done=0.
  - Reset mid-operation abandons the multiply. result reads 0 and no done pulse is issued.
- Internal registers:
  - acc, mcand, mplier, each 32 bits.
  - result is a registered copy of acc, loaded on entry to DONE.
- Idle/done bus value: in IDLE and DONE, alu_op=ALU_ADD, alu_port_a=0, alu_port_b=0.
- IDLE:
  - On start=1: acc<=0, mcand<=op_a, mplier<=op_b.
  - Next state is DONE if op_b==0 and EARLY_TERM=1; otherwise STEP.
  - start=0: stay in IDLE.
- STEP, when mplier[0]=1:
  - Drive ALU_ADD, port_a=acc, port_b=mcand.
  - acc<=alu_out (wraps mod 2^32). Next state SHIFT.
- STEP, when mplier[0]=0: perform the SHIFT actions in this same cycle.
- SHIFT:
  - Drive ALU_SLL, port_a=mcand, port_b=32'd1.
  - mcand<=alu_out, mplier<=mplier>>1 (logical), bit counter +1.
  - Next state is DONE if EARLY_TERM=1 and (mplier>>1)==0.
  - Next state is also DONE if 32 bits have been processed.
  - Otherwise next state is STEP.
- DONE:
  - done=1 and busy=1 for exactly one cycle, with result=acc.
  - Next state is IDLE.
  - A new start is accepted in the following IDLE cycle at the earliest.
- Latency (EARLY_TERM=1, op_b≠0):
  - Cycles spent in STEP/SHIFT = (index of MSB of op_b + 1) + popcount(op_b).
  - done asserts that many cycles plus 1 after the accept edge.
  - op_b==0: done asserts in the cycle after the accept edge.
- Latency (EARLY_TERM=0): 32 + popcount(op_b) cycles in STEP/SHIFT. For op_b==0 this is 32 cycles of SHIFT.
- Boundary conditions:
  - start while busy: ignored, no queueing; op_a/op_b changes are ignored.
  - start held high: a new multiply begins on each return to IDLE.
  - Signedness: the low 32 bits are identical for signed and unsigned operands, so no sign handling.
  - ALU OVER/ZERO/NEG: ignored by this block.

Test Plan:
- op_a=3, op_b=5, EARLY_TERM=1 -> result=15; done 6 cycles after accept; ALU sequence ADD, SLL, SLL, ADD, SLL.
- op_a=0x1234, op_b=0 -> done in the cycle after accept; result=0; no ALU_SLL issued. Repeat with EARLY_TERM=0 -> 32 SLL cycles, result=0.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001; 64 STEP/SHIFT cycles; done once.
- op_a=0x80000000, op_b=2 -> result=0 (wrap); op_a=7, op_b=0x80000000 -> result=0x80000000 after 33 cycles.
- Mid-run start=1 with different operands -> ignored; first result (e.g. 6*7=42) is unchanged.
- nRST low during SHIFT -> next edge: busy=0, done=0, result=0, state IDLE; a subsequent 2*3 yields 6.
